// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks a 4-input netlist through all 16 minterms,
// captures y0 per minterm and compares the table against an expected pattern.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected_tt,
  output logic [3:0]  x_out,
  input  logic        y_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic        match,
  output logic        match_neg,
  output logic        fail_valid,
  output logic [3:0]  first_fail
);
  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_e;

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  settle_cnt_q, settle_cnt_d;
  logic [15:0] exp_q, exp_d;
  logic [15:0] tt_q, tt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        match_q, match_d;
  logic        match_neg_q, match_neg_d;
  logic        fail_valid_q, fail_valid_d;
  logic [3:0]  first_fail_q, first_fail_d;
  logic [15:0] diff;

  assign diff = tt_q ^ exp_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    exp_d        = exp_q;
    tt_d         = tt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    match_d      = match_q;
    match_neg_d  = match_neg_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          idx_d        = 4'd0;
          settle_cnt_d = 4'd0;
          exp_d        = expected_tt;
          tt_d         = 16'h0000;
          busy_d       = 1'b1;
          match_d      = 1'b0;
          match_neg_d  = 1'b0;
          fail_valid_d = 1'b0;
          first_fail_d = 4'd0;
        end
      end
      RUN: begin
        // Sample on the last cycle of each minterm's hold window.
        if (settle_cnt_q == SETTLE) begin
          tt_d[idx_q]  = y_in;
          settle_cnt_d = 4'd0;
          if (idx_q == 4'd15) state_d = CHECK;
          else                idx_d   = idx_q + 4'd1;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      CHECK: begin
        match_d      = (diff == 16'h0000);
        match_neg_d  = (diff == 16'hFFFF);
        fail_valid_d = (diff != 16'h0000);
        first_fail_d = 4'd0;
        // Scan downward so the lowest mismatching index wins.
        for (int i = 15; i >= 0; i--) begin
          if (diff[i]) first_fail_d = 4'(i);
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      settle_cnt_q <= 4'd0;
      exp_q        <= 16'h0000;
      tt_q         <= 16'h0000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      match_neg_q  <= 1'b0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      exp_q        <= exp_d;
      tt_q         <= tt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      match_q      <= match_d;
      match_neg_q  <= match_neg_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign x_out      = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tt         = tt_q;
  assign match      = match_q;
  assign match_neg  = match_neg_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;
endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (SETTLE_CYCLES 1 and 0) driven by a
// truth-table netlist model, results checked against a plain-arithmetic model.
module tb_tt_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b1;   // 1: SETTLE_CYCLES=1 instance, 0: SETTLE_CYCLES=0
  logic        start = 1'b0;
  logic [15:0] exp_in = 16'h0;
  logic [15:0] fn = 16'h0;

  logic        start1, start0, y1, y0;
  logic [3:0]  x1, x0, ff1, ff0;
  logic        busy1, busy0, done1, done0, m1, m0, mn1, mn0, fv1, fv0;
  logic [15:0] tt1, tt0;

  assign start1 = start & sel;
  assign start0 = start & ~sel;
  assign y1 = fn[x1];
  assign y0 = fn[x0];

  tt_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected_tt(exp_in),
    .x_out(x1), .y_in(y1), .busy(busy1), .done(done1), .tt(tt1),
    .match(m1), .match_neg(mn1), .fail_valid(fv1), .first_fail(ff1));

  tt_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected_tt(exp_in),
    .x_out(x0), .y_in(y0), .busy(busy0), .done(done0), .tt(tt0),
    .match(m0), .match_neg(mn0), .fail_valid(fv0), .first_fail(ff0));

  logic [3:0]  x_m, ff_m;
  logic        busy_m, done_m, m_m, mn_m, fv_m;
  logic [15:0] tt_m;
  always_comb begin
    x_m = sel ? x1 : x0;
    busy_m = sel ? busy1 : busy0;
    done_m = sel ? done1 : done0;
    tt_m = sel ? tt1 : tt0;
    m_m = sel ? m1 : m0;
    mn_m = sel ? mn1 : mn0;
    fv_m = sel ? fv1 : fv0;
    ff_m = sel ? ff1 : ff0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int lowest_diff(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < 16; i++) if (a[i] != b[i]) return i;
    return 0;
  endfunction

  task automatic check_results(input string tag, input logic [15:0] f, input logic [15:0] e);
    chk({tag, ".tt"}, 32'(tt_m), 32'(f));
    chk({tag, ".match"}, 32'(m_m), 32'(f == e));
    chk({tag, ".match_neg"}, 32'(mn_m), 32'(f == ~e));
    chk({tag, ".fail_valid"}, 32'(fv_m), 32'(f != e));
    chk({tag, ".first_fail"}, 32'(ff_m), 32'(lowest_diff(f, e)));
  endtask

  // One complete sweep. b2b: start is raised right after the sampling point of
  // the previous done (no re-sync). inject: stray starts at edges 5 and 20.
  task automatic sweep(input string tag, input logic s1, input logic [15:0] f,
                       input logic [15:0] e, input bit b2b, input bit inject,
                       input bit hold_chk);
    int s, lat, bad, want_idx;
    s = s1 ? 1 : 0;
    if (!b2b) @(negedge clk);
    sel = s1; fn = f; exp_in = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_in = ~e;  // later changes of expected_tt must not matter
    chk({tag, ".start"}, {busy_m, done_m, m_m, mn_m, fv_m, tt_m}, {5'b10000, 16'h0});
    lat = 0; bad = 0;
    while (!done_m && lat < 200) begin
      start = inject && (lat == 4 || lat == 19);
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      want_idx = lat / (s + 1);
      if (want_idx > 15) want_idx = 15;
      if (32'(x_m) != want_idx) bad++;
      if (!done_m && !busy_m) bad++;
    end
    chk({tag, ".latency"}, lat, 16 * (s + 1) + 1);
    chk({tag, ".xwalk"}, bad, 0);
    chk({tag, ".busy_end"}, 32'(busy_m), 0);
    check_results(tag, f, e);
    if (hold_chk) begin
      @(posedge clk); #1;
      chk({tag, ".done_once"}, 32'(done_m), 0);
      check_results({tag, ".hold"}, f, e);
    end
  endtask

  initial begin
    int n;
    logic [15:0] f, e;
    #12;
    chk("reset", {busy1, done1, x1, tt1, m1, mn1, fv1, ff1, busy0, done0, x0, tt0}, 0);
    @(negedge clk) rst_n = 1'b1;

    sweep("and4",  1'b1, 16'h8000, 16'h8000, 0, 0, 1);
    sweep("parity", 1'b1, 16'h6996, 16'h9669, 0, 0, 1);
    sweep("x3",    1'b1, 16'hFF00, 16'hFE00, 0, 0, 1);

    // Async reset mid-sweep at idx 7.
    @(negedge clk);
    sel = 1'b1; fn = 16'h1234; exp_in = 16'h1234; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (x_m != 4'd7 && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_idx7", 32'(x_m), 7);
    #2 rst_n = 1'b0;
    #1 chk("midreset", {busy_m, done_m, x_m, tt_m, m_m, mn_m, fv_m, ff_m}, 0);
    @(negedge clk) rst_n = 1'b1;
    sweep("x0_after_rst", 1'b1, 16'hAAAA, 16'hAAAA, 0, 0, 1);

    // Stray starts ignored, then back-to-back sweep from the done cycle.
    sweep("ignore", 1'b1, 16'h0F0F, 16'h0F0E, 0, 1, 0);
    sweep("b2b", 1'b1, 16'h3C3C, 16'h3C3C, 1, 0, 1);

    sweep("maj_s0", 1'b0, 16'hE8E8, 16'hE8E8, 0, 0, 1);
    sweep("zero_s0", 1'b0, 16'h0000, 16'hFFFF, 0, 0, 0);
    sweep("ones_s1", 1'b1, 16'hFFFF, 16'hFFFF, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      f = 16'($urandom);
      case ($urandom_range(0, 2))
        0: e = f;
        1: e = ~f;
        default: e = f ^ 16'($urandom_range(1, 65535));
      endcase
      sweep($sformatf("rnd%0d", k), k[0], f, e, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that exhaustively exercises one 4-input single-output combinational function netlist (inputs x0..x3, output y0), captures its 16-bit truth table and compares it against an expected table. It also checks for a match under output negation. It sits beside the exact-synthesis netlists as a self-check and characterisation controller: it drives the netlist inputs, waits a programmable settle time, samples the output and reports through a start/busy/done handshake.

## Interface
- SETTLE_CYCLES, default 1: extra hold cycles per minterm before sampling. Legal range 0..15.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a sweep; accepted only when not busy.
- expected_tt  in  16  expected truth table. Bit i is the output for input pattern i. Latched on start acceptance.
- x_out  out  4  drives netlist inputs: x_out[0]→x0 … x_out[3]→x3.
- y_in  in  1  netlist output y0; combinational from x_out.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when results become valid.
- tt  out  16  captured truth table.
- match  out  1  tt == latched expected.
- match_neg  out  1  tt == ~latched expected.
- fail_valid  out  1  high when match is 0 after a completed sweep.
- first_fail  out  4  lowest index i with tt[i] ≠ expected[i]; 0 when fail_valid is 0.

## Operation
- States: IDLE, RUN, CHECK.
- Registers: idx (4 bit), settle_cnt (4 bit), exp_q (16 bit).
- IDLE → RUN on start:
  - idx ← 0, settle_cnt ← 0, exp_q ← expected_tt, tt ← 0.
  - match, match_neg, fail_valid, first_fail ← 0.
  - busy ← 1.
- RUN, each cycle:
  - If settle_cnt == SETTLE_CYCLES: tt[idx] ← y_in and settle_cnt ← 0.
    - If idx == 15, go to CHECK.
    - Otherwise idx ← idx+1.
  - Otherwise settle_cnt ← settle_cnt+1.
- x_out = idx at all times. It holds the last index after the sweep; it is 0 after reset.
- CHECK, one cycle, then IDLE:
  - Compute match, match_neg, fail_valid and first_fail (priority encode of tt ^ exp_q, lowest set bit).
  - busy ← 0, done ← 1 for one cycle.
- Results hold until the next accepted start.
- start while busy (RUN or CHECK) is ignored and not queued.
- start in the cycle done is high is accepted, since the state is IDLE; back-to-back sweeps are legal.
- tt == exp_q and tt == ~exp_q are mutually exclusive, so match and match_neg are never both 1.
- Constant-output netlists are handled normally: 0x0000 or 0xFFFF sweep like any other function.

## Timing
- Reset value of every output is 0: busy, done, x_out, tt, match, match_neg, fail_valid, first_fail. State resets to IDLE.
- Let edge 0 be the rising edge where start is accepted.
- Each minterm is driven for SETTLE_CYCLES+1 cycles. y_in is sampled on the edge that ends its window:
  - minterm i is sampled at edge (SETTLE_CYCLES+1)·(i+1);
  - at least one full cycle of combinational settle is guaranteed even with SETTLE_CYCLES = 0.
- Latency from edge 0:
  - done goes high after edge 16·(SETTLE_CYCLES+1)+1;
  - busy is high from edge 0 through that edge;
  - SETTLE_CYCLES=1 gives 33 edges; SETTLE_CYCLES=0 gives 17.
- Reset asserted mid-sweep asynchronously clears all state and outputs; a partial tt is discarded.
- expected_tt may change after acceptance without effect.

## Test plan
- AND4 model (y = x0&x1&x2&x3), expected 0x8000, SETTLE_CYCLES=1 → tt=0x8000, match=1, match_neg=0, fail_valid=0, first_fail=0; done pulses once, after edge 33; x_out walks 0..15, each value held 2 cycles.
- Parity model (y = x0^x1^x2^x3, tt 0x6996), expected 0x9669 → match=0, match_neg=1, fail_valid=1, first_fail=0.
- Model y = x3 (0xFF00), expected 0xFE00 → match=0, match_neg=0, fail_valid=1, first_fail=8.
- Assert rst_n low while idx=7 → all outputs 0 immediately, before the next clock edge. Release reset and start with y = x0 (0xAAAA), expected 0xAAAA → match=1.
- Pulse start at edges 5 and 20 of a running sweep → ignored, exactly one done. Assert start in the done cycle → new sweep begins next cycle, match etc. cleared, second done 33 edges later.
- SETTLE_CYCLES=0, majority-of-x0,x1,x2 model (0xE8E8), expected 0xE8E8 → match=1, done after edge 17.
